crc_frame_rx: RTL

- Receive-side end of the CRC-protected link. Accepts a byte stream carrying one frame: DATA_WIDTH payload bits followed by the CRC_WIDTH-bit code that crc_generator_seq appended, MSB first.
- Reassembles the frame and checks the CRC sequentially, XOR_OPS_PER_CYCLE bits per cycle.
- Presents the payload downstream with a pass/fail flag and a framing-error flag.
- Sits between the byte deserializer and the FEC decoder input.

---
 rtl/crc_pkg.sv | 39 +++
 rtl/crc_frame_rx_core.sv | 74 +++++++
 rtl/crc_frame_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared CRC definitions: the default polynomial, the receiver state encoding
// and the bit-serial residue update shared with the generator and verifier.
package crc_pkg;

    localparam logic [8:0] CRC8_POLY = 9'h107;
    localparam int CRC_MAX  = 32;
    localparam int STEP_MAX = 128;

    typedef enum logic [1:0] {COLLECT, DRAIN, CHECK, OUTPUT} crc_state_e;

    // Consumes n bits of 'bits' MSB first. Bits are left-aligned, so bit
    // STEP_MAX-1 is the first one taken. Only the low crc_w bits of rem and poly count.
    function automatic logic [CRC_MAX-1:0] crc_step(
        input logic [CRC_MAX-1:0]  rem,
        input logic [STEP_MAX-1:0] bits,
        input int                  n,
        input int                  crc_w,
        input logic [CRC_MAX-1:0]  poly
    );
        logic [CRC_MAX-1:0]  r;
        logic [CRC_MAX-1:0]  mask;
        logic [CRC_MAX-1:0]  top;
        logic [STEP_MAX-1:0] bl;
        logic                fb;
        mask = (crc_w >= CRC_MAX) ? '1 : CRC_MAX'((64'd1 << crc_w) - 64'd1);
        r    = rem & mask;
        bl   = bits;
        for (int i = 0; i < STEP_MAX; i++) begin
            if (i < n) begin
                top = r >> (crc_w - 1);
                fb  = top[0] ^ bl[STEP_MAX-1];
                r   = ((r << 1) & mask) ^ (fb ? (poly & mask) : '0);
                bl  = bl << 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_frame_rx_core.sv
// Sequential CRC residue engine: after a start pulse it walks the frame
// XOR_OPS_PER_CYCLE bits per cycle and raises done once every bit is consumed.
module crc_residue_core
    import crc_pkg::*;
#(
    parameter int                   TOTAL             = 64,
    parameter int                   CRC_WIDTH         = 8,
    parameter logic [CRC_WIDTH-1:0] POLY_LO           = 8'h07,
    parameter logic [CRC_WIDTH-1:0] SEED              = '0,
    parameter int                   XOR_OPS_PER_CYCLE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [TOTAL-1:0] frame,
    output logic             done,
    output logic             rem_zero
);

    localparam int K     = XOR_OPS_PER_CYCLE;
    localparam int C     = (TOTAL + K - 1) / K;
    localparam int PADW  = C * K;
    localparam int LASTN = TOTAL - (C - 1) * K;
    localparam int PW    = $clog2(C + 1);

    logic [CRC_WIDTH-1:0] rem;
    logic [PW-1:0]        ptr;
    logic                 active;
    logic [PADW-1:0]      padded;
    logic [PADW-1:0]      shifted;
    logic [K-1:0]         chunk;
    logic [STEP_MAX-1:0]  bits_al;
    logic [CRC_MAX-1:0]   step_full;
    logic [CRC_WIDTH-1:0] rem_next;
    int                   n_bits;

    // Zero-pad the tail so every cycle can slice a full K-bit chunk.
    assign padded  = PADW'(frame) << (PADW - TOTAL);
    assign shifted = padded << (K * int'(ptr));
    assign chunk   = shifted[PADW-1 -: K];
    assign bits_al = STEP_MAX'(chunk) << (STEP_MAX - K);

    always_comb begin
        n_bits    = (ptr == PW'(C - 1)) ? LASTN : K;
        step_full = crc_step(CRC_MAX'(rem), bits_al, n_bits, CRC_WIDTH, CRC_MAX'(POLY_LO));
        rem_next  = step_full[CRC_WIDTH-1:0];
    end

    assign done     = active && (ptr == PW'(C));
    assign rem_zero = (rem == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= SEED;
            ptr    <= '0;
            active <= 1'b0;
        end else if (start) begin
            rem    <= SEED;
            ptr    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (ptr != PW'(C)) begin
                rem <= rem_next;
                ptr <= ptr + 1'b1;
            end else begin
                // Result is sampled by the FSM on this edge; rearm for the next frame.
                rem    <= SEED;
                ptr    <= '0;
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/crc_frame_rx.sv
// Receive end of the CRC link: collects one frame from the byte stream, checks
// its CRC sequentially and hands payload plus pass/fail and length flags downstream.
module crc_frame_rx
    import crc_pkg::*;
#(
    parameter int                   DATA_WIDTH        = 56,
    parameter int                   CRC_WIDTH         = 8,
    parameter logic [CRC_WIDTH:0]   POLY              = CRC8_POLY,
    parameter logic [CRC_WIDTH-1:0] SEED              = '0,
    parameter int                   XOR_OPS_PER_CYCLE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_crc_ok,
    output logic                  m_len_err,
    output logic                  busy
);

    localparam int TOTAL  = DATA_WIDTH + CRC_WIDTH;
    localparam int NBYTES = TOTAL / 8;
    localparam int CW     = $clog2(NBYTES + 1);

    if (TOTAL % 8 != 0) begin : g_bad_total
        $fatal(1, "crc_frame_rx: frame length must be a whole number of bytes");
    end
    if (XOR_OPS_PER_CYCLE < 1 || XOR_OPS_PER_CYCLE > TOTAL || TOTAL > STEP_MAX) begin : g_bad_ops
        $fatal(1, "crc_frame_rx: XOR_OPS_PER_CYCLE out of range");
    end

    crc_state_e       state, state_nxt;
    logic [CW-1:0]    count;
    logic [TOTAL-1:0] frame;
    logic [TOTAL-1:0] frame_in;
    logic [TOTAL-1:0] aligned;
    logic             accept;
    logic             last_byte;
    logic             start;
    logic             done;
    logic             rem_zero;

    assign accept    = s_valid && ((state == COLLECT) || (state == DRAIN));
    assign last_byte = (count == CW'(NBYTES - 1));
    assign frame_in  = (frame << 8) | TOTAL'(s_data);
    // Short frame: push the bytes received so far to the top, zero below.
    assign aligned   = frame_in << (8 * (NBYTES - 1 - int'(count)));

    crc_residue_core #(
        .TOTAL             (TOTAL),
        .CRC_WIDTH         (CRC_WIDTH),
        .POLY_LO           (POLY[CRC_WIDTH-1:0]),
        .SEED              (SEED),
        .XOR_OPS_PER_CYCLE (XOR_OPS_PER_CYCLE)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .frame    (frame),
        .done     (done),
        .rem_zero (rem_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept) begin
                if (last_byte)   state_nxt = s_last ? CHECK : DRAIN;
                else if (s_last) state_nxt = OUTPUT;
            end
            DRAIN:   if (accept && s_last) state_nxt = OUTPUT;
            CHECK:   if (done)             state_nxt = OUTPUT;
            OUTPUT:  if (m_ready)          state_nxt = COLLECT;
            default:                       state_nxt = COLLECT;
        endcase
    end

    always_comb begin
        s_ready = (state == COLLECT) || (state == DRAIN);
        m_valid = (state == OUTPUT);
        busy    = (state != COLLECT) || (count != '0);
        start   = (state == COLLECT) && accept && last_byte && s_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            frame     <= '0;
            m_data    <= '0;
            m_crc_ok  <= 1'b0;
            m_len_err <= 1'b0;
        end else begin
            case (state)
                COLLECT: if (accept) begin
                    frame <= frame_in;
                    count <= count + 1'b1;
                    if (!last_byte && s_last) begin
                        m_data    <= aligned[TOTAL-1:CRC_WIDTH];
                        m_crc_ok  <= 1'b0;
                        m_len_err <= 1'b1;
                    end else if (last_byte && !s_last) begin
                        m_len_err <= 1'b1;
                    end
                end
                DRAIN: if (accept && s_last) begin
                    m_data   <= frame[TOTAL-1:CRC_WIDTH];
                    m_crc_ok <= 1'b0;
                end
                CHECK: if (done) begin
                    m_data    <= frame[TOTAL-1:CRC_WIDTH];
                    m_crc_ok  <= rem_zero;
                    m_len_err <= 1'b0;
                end
                OUTPUT: if (m_ready) begin
                    count     <= '0;
                    frame     <= '0;
                    m_data    <= '0;
                    m_crc_ok  <= 1'b0;
                    m_len_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
